// File: rtl/soc_stim_gen.sv
// rtl/soc_stim_gen.sv - SoC stimulus sequencer: delayed reset pulse, then timed VCO enable with per-channel toggles
module soc_stim_gen #(
  parameter int NUM_CH  = 2,
  parameter int DIV_W   = 8,
  parameter int CNT_W   = 16,
  parameter int RST_DLY = 20,
  parameter int RST_LEN = 100
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CH*DIV_W-1:0] half_period,
  input  logic [CNT_W-1:0]        run_len,
  output logic                    soc_reset,
  output logic                    enb,
  output logic [NUM_CH-1:0]       ch_out,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        cycle_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RESET, S_RUN, S_DONE} state_t;

  state_t                         state;
  logic [31:0]                    timer;
  logic [NUM_CH*DIV_W-1:0]        hp_q;
  logic [CNT_W-1:0]               run_len_q;
  logic [NUM_CH-1:0][DIV_W-1:0]   div_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= S_IDLE;
      timer     <= '0;
      hp_q      <= '0;
      run_len_q <= '0;
      div_cnt   <= '0;
      soc_reset <= 1'b0;
      enb       <= 1'b0;
      ch_out    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      done <= 1'b0;
      // Abort leaves cycle_cnt untouched so the partial run length stays visible.
      if (abort && (state == S_DELAY || state == S_RESET || state == S_RUN)) begin
        state     <= S_IDLE;
        soc_reset <= 1'b0;
        enb       <= 1'b0;
        ch_out    <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state     <= S_DELAY;
              hp_q      <= half_period;
              run_len_q <= run_len;
              timer     <= 32'(RST_DLY - 1);
              cycle_cnt <= '0;
              busy      <= 1'b1;
            end
          end
          S_DELAY: begin
            if (timer == 32'd0) begin
              state     <= S_RESET;
              timer     <= 32'(RST_LEN - 1);
              soc_reset <= 1'b1;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          S_RESET: begin
            if (timer == 32'd0) begin
              soc_reset <= 1'b0;
              if (run_len_q == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state  <= S_RUN;
                enb    <= 1'b1;
                timer  <= 32'(run_len_q) - 32'd1;
                ch_out <= '0;
                for (int i = 0; i < NUM_CH; i++)
                  div_cnt[i] <= hp_q[i*DIV_W +: DIV_W] - DIV_W'(1);
              end
            end else begin
              timer <= timer - 32'd1;
            end
          end
          S_RUN: begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (timer == 32'd0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              enb    <= 1'b0;
              ch_out <= '0;
            end else begin
              timer <= timer - 32'd1;
              // A zero half-period parks the channel at 0 for the whole run.
              for (int i = 0; i < NUM_CH; i++) begin
                if (hp_q[i*DIV_W +: DIV_W] != '0) begin
                  if (div_cnt[i] == '0) begin
                    ch_out[i]  <= ~ch_out[i];
                    div_cnt[i] <= hp_q[i*DIV_W +: DIV_W] - DIV_W'(1);
                  end else begin
                    div_cnt[i] <= div_cnt[i] - DIV_W'(1);
                  end
                end
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_soc_stim_gen.sv
// tb/tb_soc_stim_gen.sv - directed bench for soc_stim_gen with hand-derived timing expectations
module tb_soc_stim_gen;

  logic        CLK = 1'b0;
  logic        reset, start, abort;
  logic [15:0] half_period;
  logic [15:0] run_len;
  logic        soc_reset, enb, busy, done;
  logic [1:0]  ch_out;
  logic [15:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  soc_stim_gen dut (
    .CLK(CLK), .reset(reset), .start(start), .abort(abort),
    .half_period(half_period), .run_len(run_len),
    .soc_reset(soc_reset), .enb(enb), .ch_out(ch_out),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Output vector {soc_reset, enb, done, busy, ch1, ch0}; k counts edges after the start edge.
  task automatic run_seq(input string tag, input int rl, input int h0, input int h1,
                         input int restart_at, input int change_at);
    logic [5:0] exp;
    logic       e0, e1;
    int         j;
    half_period = {8'(h1), 8'(h0)};
    run_len     = 16'(rl);
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= rl + 130; k++) begin
      if (k > 0) tick();
      j  = k - 120;
      e0 = (k >= 120 && k < 120 + rl && h0 != 0) ? 1'((j / h0) % 2) : 1'b0;
      e1 = (k >= 120 && k < 120 + rl && h1 != 0) ? 1'((j / h1) % 2) : 1'b0;
      exp = {(k >= 20 && k < 120), (k >= 120 && k < 120 + rl), (k == 120 + rl),
             (k <= 120 + rl), e1, e0};
      check($sformatf("%s k=%0d", tag, k), 32'({soc_reset, enb, done, busy, ch_out}), 32'(exp));
      if (k == restart_at) start = 1'b1;
      if (k == restart_at + 1) start = 1'b0;
      if (k == change_at) begin
        half_period = 16'h0101;
        run_len     = 16'd5;
      end
    end
    check({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'(rl));
  endtask

  initial begin
    logic seen_done;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    half_period = 16'h0000; run_len = 16'd0;
    tick(); tick();
    check("reset outs", 32'({soc_reset, enb, done, busy, ch_out}), 32'd0);
    check("reset cnt", 32'(cycle_cnt), 32'd0);
    reset = 1'b0;
    tick();

    run_seq("basic", 30, 5, 3, -1, -1);
    run_seq("zero_len", 0, 5, 3, -1, -1);
    run_seq("ignore", 30, 5, 3, 50, 135);
    run_seq("h0_h1", 8, 0, 1, -1, -1);

    // Abort ten cycles into RUN
    half_period = {8'd3, 8'd5}; run_len = 16'd30;
    start = 1'b1; tick(); start = 1'b0;
    repeat (130) tick();
    check("abort pre enb", 32'(enb), 32'd1);
    check("abort pre cnt", 32'(cycle_cnt), 32'd10);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort outs", 32'({soc_reset, enb, done, busy, ch_out}), 32'd0);
    check("abort cnt", 32'(cycle_cnt), 32'd10);
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) seen_done = 1'b1;
    end
    check("abort quiet", 32'(seen_done), 32'd0);
    check("abort cnt hold", 32'(cycle_cnt), 32'd10);

    // Abort during DELAY
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort delay busy", 32'(busy), 32'd0);
    check("abort delay cnt", 32'(cycle_cnt), 32'd0);

    // start with abort in IDLE stays idle
    start = 1'b1; abort = 1'b1; tick();
    check("start+abort", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0; tick();
    check("start+abort after", 32'(busy), 32'd0);

    // Reset together with start mid-RUN
    start = 1'b1; tick(); start = 1'b0;
    repeat (125) tick();
    check("pre reset enb", 32'(enb), 32'd1);
    reset = 1'b1; start = 1'b1; tick();
    check("mid reset outs", 32'({soc_reset, enb, done, busy, ch_out}), 32'd0);
    check("mid reset cnt", 32'(cycle_cnt), 32'd0);
    reset = 1'b0; start = 1'b0; tick();
    check("post reset idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
